tt_sweep: RTL and testbench

TT_SWEEP -- requirements
Module: tt_sweep

---
 rtl/tt_pkg.sv | 16 +
 rtl/tt_sweep_if.sv | 24 ++
 rtl/dwell_timer.sv | 28 ++
 rtl/tt_sweep.sv | 103 ++++++++++
 tb/tb_tt_sweep.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Holds the FSM state encoding, vector count and vector width.
package tt_pkg;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

endpackage

// File: rtl/tt_sweep_if.sv
// Bundle of the sweeper control, stimulus and result signals.
// master: drives start/f_in; slave: drives abcd/busy/done/truth/ones.
interface tt_sweep_if;
  import tt_pkg::*;

  logic               start;
  logic [VEC_W-1:0]   abcd;
  logic               f_in;
  logic               busy;
  logic               done;
  logic [NUM_VEC-1:0] truth;
  logic [4:0]         ones;

  modport master (
    output start, f_in,
    input  abcd, busy, done, truth, ones
  );

  modport slave (
    input  start, f_in,
    output abcd, busy, done, truth, ones
  );

endinterface

// File: rtl/dwell_timer.sv
// Dwell counter: counts enabled cycles, flags the last one of DWELL.
// Ports: clk, rst (sync, high), i_clr, i_en in; o_tc terminal count out.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] r_cnt;

  // With DWELL=1 the count stays 0 so every enabled cycle is terminal.
  assign o_tc = i_en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? 8'd0 : r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/tt_sweep.sv
// Sweeps abcd over 0..15, holding each DWELL cycles, and captures f_in.
// Ports: clk, rst, start, f_in in; abcd, busy, done, truth, ones out.
module tt_sweep
  import tt_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [VEC_W-1:0]   abcd,
  input  logic               f_in,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] truth,
  output logic [4:0]         ones
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [VEC_W-1:0]   r_vec;
  logic [NUM_VEC-1:0] r_truth;
  logic [4:0]         r_ones;
  logic               w_en;
  logic               w_tc;
  logic               w_busy;
  logic               w_done;
  logic [VEC_W-1:0]   w_abcd;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state != S_DRIVE),
    .i_en  (w_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_abcd      = '0;
    w_en        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_busy = 1'b1;
        w_abcd = r_vec;
        w_en   = 1'b1;
        if (w_tc && (r_vec == LAST_VEC)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Results change only at sample edges; a new start wipes the last run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec   <= '0;
      r_truth <= '0;
      r_ones  <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_vec   <= '0;
      r_truth <= '0;
      r_ones  <= '0;
    end else if (w_tc) begin
      r_truth[r_vec] <= f_in;
      r_ones         <= r_ones + {4'd0, f_in};
      if (r_vec != LAST_VEC) begin
        r_vec <= r_vec + 1'b1;
      end
    end
  end

  assign abcd  = w_abcd;
  assign busy  = w_busy;
  assign done  = w_done;
  assign truth = r_truth;
  assign ones  = r_ones;

endmodule

// File: tb/tb_tt_sweep.sv
// Scoreboard bench for tt_sweep: DWELL=4 and DWELL=1 instances.
// Expected results are queued at start; monitors compare on done.
module tb_tt_sweep;
  import tt_pkg::*;

  typedef struct {
    logic [15:0] t;
    logic [4:0]  o;
    int          cy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   m4 = 2;
  int   m1 = 3;

  exp_t q4[$];
  exp_t q1[$];

  tt_sweep_if d4 ();
  tt_sweep_if d1 ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic fn(int m, logic [3:0] v);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ^v;
      default: return (v[3] & v[2]) | (v[1] & v[0]);
    endcase
  endfunction

  assign d4.f_in = fn(m4, d4.abcd);
  assign d1.f_in = fn(m1, d1.abcd);

  tt_sweep #(.DWELL(4)) u4 (
    .clk   (clk),
    .rst   (rst),
    .start (d4.start),
    .abcd  (d4.abcd),
    .f_in  (d4.f_in),
    .busy  (d4.busy),
    .done  (d4.done),
    .truth (d4.truth),
    .ones  (d4.ones)
  );

  tt_sweep #(.DWELL(1)) u1 (
    .clk   (clk),
    .rst   (rst),
    .start (d1.start),
    .abcd  (d1.abcd),
    .f_in  (d1.f_in),
    .busy  (d1.busy),
    .done  (d1.done),
    .truth (d1.truth),
    .ones  (d1.ones)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (d4.done === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL u4_done actual=unexpected_pulse required=none cyc=%0d", cyc);
      end else begin
        e = q4.pop_front();
        chk("u4_truth", 32'(d4.truth), 32'(e.t));
        chk("u4_ones", 32'(d4.ones), 32'(e.o));
        chk("u4_done_cycle", 32'(cyc), 32'(e.cy));
      end
    end
    if (d1.done === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL u1_done actual=unexpected_pulse required=none cyc=%0d", cyc);
      end else begin
        e = q1.pop_front();
        chk("u1_truth", 32'(d1.truth), 32'(e.t));
        chk("u1_ones", 32'(d1.ones), 32'(e.o));
        chk("u1_done_cycle", 32'(cyc), 32'(e.cy));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go4(logic [15:0] t, logic [4:0] o);
    q4.push_back('{t, o, cyc + 1 + 64});
    d4.start = 1'b1;
    tick();
    d4.start = 1'b0;
  endtask

  task automatic go1(logic [15:0] t, logic [4:0] o);
    q1.push_back('{t, o, cyc + 1 + 16});
    d1.start = 1'b1;
    tick();
    d1.start = 1'b0;
  endtask

  task automatic drain(int lim);
    int n;
    n = 0;
    while (((q4.size() + q1.size()) != 0) && (n < lim)) begin
      tick();
      n++;
    end
    if ((q4.size() + q1.size()) != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", q4.size() + q1.size());
      q4.delete();
      q1.delete();
    end
  endtask

  initial begin
    int nb;
    int bad;
    int w;
    int c;
    int x;
    d4.start = 1'b0;
    d1.start = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_state_u4", 32'({d4.abcd, d4.busy, d4.done, d4.truth, d4.ones}), 32'd0);
    chk("reset_state_u1", 32'({d1.abcd, d1.busy, d1.done, d1.truth, d1.ones}), 32'd0);
    rst = 1'b0;
    tick();

    // Parity sweep, DWELL=4
    m4 = 2;
    go4(16'h6996, 5'd8);
    nb = 0;
    repeat (70) begin
      nb += int'(d4.busy);
      tick();
    end
    chk("u4_busy_cycles", 32'(nb), 32'd64);
    drain(20);

    // Constant 0 then constant 1; each start clears the previous result
    m4 = 0;
    go4(16'h0000, 5'd0);
    chk("clear_on_start", 32'({d4.truth, d4.ones}), 32'd0);
    drain(80);
    m4 = 1;
    go4(16'hFFFF, 5'd16);
    repeat (16) tick();
    chk("partial_result", 32'({d4.truth, d4.ones}), 32'({16'h000F, 5'd4}));
    drain(80);

    // DWELL=1, f = a&b | c&d, vector steps once per cycle
    m1 = 3;
    go1(16'hF888, 5'd7);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (d1.abcd !== 4'(k)) bad++;
      tick();
    end
    chk("u1_abcd_steps", 32'(bad), 32'd0);
    drain(20);

    // Reset mid-sweep while abcd==7
    m4 = 2;
    go4(16'h6996, 5'd8);
    w = 0;
    while ((d4.abcd !== 4'd7) && (w < 100)) begin
      tick();
      w++;
    end
    chk("reach_vec7", 32'(d4.abcd), 32'd7);
    rst = 1'b1;
    q4.delete();
    tick();
    rst = 1'b0;
    chk("rst_mid_sweep", 32'({d4.abcd, d4.busy, d4.done, d4.truth, d4.ones}), 32'd0);
    repeat (70) tick();
    go4(16'h6996, 5'd8);
    drain(80);

    // Start pulses in cycle 5 and in DONE are ignored
    c = cyc;
    go4(16'h6996, 5'd8);
    while (cyc < c + 5) tick();
    d4.start = 1'b1;
    tick();
    d4.start = 1'b0;
    while (cyc < c + 65) tick();
    chk("done_in_cycle65", 32'(d4.done), 32'd1);
    d4.start = 1'b1;
    tick();
    d4.start = 1'b0;
    nb = 0;
    repeat (20) begin
      nb += int'(d4.busy);
      tick();
    end
    chk("no_restart", 32'(nb), 32'd0);
    drain(10);

    // start held high: back-to-back sweeps with one IDLE cycle between
    m1 = 2;
    c = cyc;
    x = c + 1;
    q1.push_back('{16'h6996, 5'd8, x + 16});
    q1.push_back('{16'h6996, 5'd8, x + 34});
    q1.push_back('{16'h6996, 5'd8, x + 52});
    d1.start = 1'b1;
    while (cyc < x + 17) tick();
    chk("idle_gap", 32'({d1.busy, d1.done}), 32'd0);
    tick();
    chk("redrive_after_gap", 32'(d1.busy), 32'd1);
    while (cyc < x + 40) tick();
    d1.start = 1'b0;
    drain(100);
    nb = 0;
    repeat (20) begin
      nb += int'(d1.busy);
      tick();
    end
    chk("stop_after_release", 32'(nb), 32'd0);

    chk("queues_empty", 32'(q4.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
